// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the sequential multiply/divide unit.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic OP_DIV = 1'b0;
   localparam logic OP_MUL = 1'b1;

   // Iteration counter width; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// Shared W-bit adder/subtractor used by both the multiply and divide iterations.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operands; sub=1 gives a-b, sub=0 gives a+b; y result (carry/borrow dropped).
module muldiv_addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] y
);

   assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/seq_muldiv_unit.sv
// Iterative multiply (shift-add) / divide (restoring) engine sharing one WIDTH+1-bit add/sub.
// Latency: start accepted at edge k gives a one-cycle done pulse after edge k+WIDTH+1.
// Backpressure: start is ignored while busy=1 (no queuing); accepted again from FINISH.
// Ports: clk, rst_n; start/op/is_signed/operand_a/operand_b request; busy, done,
//        result_hi/result_lo (product hi/lo or remainder/quotient), div_by_zero.
// Optional: MULDIV_SIGNED_EN enables two's-complement operation when is_signed=1.
// WIDTH must be at least 2.
module seq_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             div_by_zero
);

   localparam int               CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic               launch, finish;
   logic [CNT_W-1:0]   cnt_q;

   // hi_q: accumulator (multiply) or partial remainder (divide).
   // lo_q: multiplier shifting out (multiply) or dividend->quotient (divide).
   // opb_q: multiplicand (multiply) or divisor (divide).
   logic [WIDTH:0]     hi_q, hi_nxt;
   logic [WIDTH-1:0]   lo_q, lo_nxt, opb_q;
   logic               op_q, neg_a_q, neg_b_q, dbz_q;

   logic               sgn_req, neg_a, neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b;

   logic [WIDTH:0]     sh_rem, alu_a, alu_b, alu_y, acc_sel;
   logic               alu_sub;

   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   res_hi, res_lo;
   logic               neg_res;

`ifdef MULDIV_SIGNED_EN
   assign sgn_req = is_signed;
`else
   logic unused_is_signed;
   assign unused_is_signed = is_signed;
   assign sgn_req          = 1'b0;
`endif

   // Signed operands are converted to magnitudes at launch; signs are
   // re-applied only when the result registers are loaded.
   assign neg_a = sgn_req & operand_a[WIDTH-1];
   assign neg_b = sgn_req & operand_b[WIDTH-1];
   assign mag_a = neg_a ? -operand_a : operand_a;
   assign mag_b = neg_b ? -operand_b : operand_b;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      finish  = 1'b0;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               launch  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (cnt_q == LAST) state_d = FINISH;
         end
         FINISH: begin
            finish = 1'b1;
            if (start) begin
               launch  = 1'b1;
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- shared datapath ----------------
   assign sh_rem  = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
   assign alu_a   = (op_q == OP_MUL) ? hi_q : sh_rem;
   assign alu_b   = {1'b0, opb_q};
   assign alu_sub = (op_q == OP_DIV);

   muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
      .a   (alu_a),
      .b   (alu_b),
      .sub (alu_sub),
      .y   (alu_y)
   );

   assign acc_sel = lo_q[0] ? alu_y : hi_q;

   always_comb begin
      hi_nxt = hi_q;
      lo_nxt = lo_q;
      if (op_q == OP_MUL) begin
         hi_nxt = {1'b0, acc_sel[WIDTH:1]};
         lo_nxt = {acc_sel[0], lo_q[WIDTH-1:1]};
      end else begin
         // MSB of the trial difference is the borrow: set means restore.
         hi_nxt = alu_y[WIDTH] ? sh_rem : alu_y;
         lo_nxt = {lo_q[WIDTH-2:0], ~alu_y[WIDTH]};
      end
   end

   // ---------------- sign fixup at result load ----------------
   assign neg_res  = neg_a_q ^ neg_b_q;
   assign prod     = {hi_q[WIDTH-1:0], lo_q};
   assign prod_fix = neg_res ? -prod : prod;

   always_comb begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
      if (op_q == OP_DIV) begin
         // Divide-by-zero keeps the natural all-ones quotient unsigned.
         res_lo = (neg_res && !dbz_q) ? -lo_q : lo_q;
         res_hi = neg_a_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         opb_q       <= '0;
         op_q        <= OP_DIV;
         neg_a_q     <= 1'b0;
         neg_b_q     <= 1'b0;
         dbz_q       <= 1'b0;
         done        <= 1'b0;
         result_hi   <= '0;
         result_lo   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= finish;
         if (finish) begin
            result_hi   <= res_hi;
            result_lo   <= res_lo;
            div_by_zero <= dbz_q;
         end
         if (launch) begin
            cnt_q   <= '0;
            op_q    <= op;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            dbz_q   <= (op == OP_DIV) && (operand_b == '0);
            hi_q    <= '0;
            lo_q    <= (op == OP_MUL) ? mag_b : mag_a;
            opb_q   <= (op == OP_MUL) ? mag_a : mag_b;
         end else if (busy) begin
            cnt_q <= cnt_q + 1'b1;
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
         end
      end
   end

endmodule

// File: doc/seq_muldiv_unit.md
Name: seq_muldiv_unit

Overview:
- Iterative unsigned multiply/divide engine: shift-add multiplication and restoring division, both using one shared WIDTH+1-bit add/sub datapath.
- Generalises the fixed 65-bit combinational multiply/divide ALU stage with a width parameter, its own sequencer, a start/done handshake, div-by-zero flagging and optional signed mode.
- Sits between the operand register file and writeback.

Parameters:
- WIDTH, 32, operand width in bits; product/remainder+quotient span 2*WIDTH; internal ALU is WIDTH+1 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- op  input  1  1 = multiply, 0 = divide
- is_signed  input  1  signed-operand request (see Optional Feature)
- operand_a  input  WIDTH  multiplicand / dividend
- operand_b  input  WIDTH  multiplier / divisor
- busy  output  1  high while computing
- done  output  1  single-cycle completion pulse
- result_hi  output  WIDTH  product upper half / remainder
- result_lo  output  WIDTH  product lower half / quotient
- div_by_zero  output  1  valid with done; high for divide with operand_b=0

Behaviour:
- Reset (async assert, sync deassert by upstream): state=IDLE; busy, done, div_by_zero, result_hi, result_lo = 0.
- FSM states IDLE, CALC, FINISH.
  - IDLE/FINISH + start → CALC: latch operands, op, is_signed; clear iteration counter; busy=1.
  - CALC runs exactly WIDTH iterations, one per cycle. Counter reaching WIDTH-1 → FINISH.
  - FINISH: done=1 for one cycle; results and div_by_zero registered; busy=0. Next cycle → IDLE unless start is present, in which case go directly to CALC (back-to-back allowed).
- Latency: start sampled at edge k → done high after edge k+WIDTH+1. Results hold until the next accepted start's FINISH. Intermediate values are never visible on outputs.
- start while busy=1 is ignored; no queuing.
- Multiply: per iteration, if the multiplier LSB is 1, add the multiplicand into the upper WIDTH+1 bits; then shift the {acc, multiplier} register right by 1. Result {result_hi, result_lo} is the exact 2*WIDTH product.
- Divide (restoring): shift {rem, quo} left by 1; trial subtract the divisor from rem (WIDTH+1 bits). If the trial result is non-negative, keep it and set the quotient LSB; else restore.
- Divide by zero: no special path. Natural result is quotient = all ones, remainder = dividend; div_by_zero=1 with done. Latency unchanged.
- div_by_zero is 0 for all multiplies.
- Reset asserted mid-operation aborts immediately to the reset state; no done pulse is produced.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - is_signed=1 treats operands as two's complement. Magnitudes are taken at launch; the sign fixup is applied combinationally at the FINISH register load, so latency is unchanged.
  - Product sign = a^b.
  - Quotient sign = a^b; remainder takes the dividend's sign.
  - MIN/-1 gives quotient=MIN, remainder=0.
  - Signed /0 gives quotient=all ones, remainder=dividend.
- Undefined: is_signed is ignored and all operations are unsigned; port still present.

Decomposition:
- Package muldiv_pkg:
  - state enum (IDLE, CALC, FINISH)
  - op encodings OP_DIV=1'b0, OP_MUL=1'b1
  - helper function for the counter width, $clog2(WIDTH)
- Sub-module muldiv_addsub: combinational WIDTH+1-bit adder/subtractor with mode select (add for multiply, subtract for divide), instantiated once.

Test Plan:
- WIDTH=8, mul 13×11 → done at k+9, result_hi=0x00, result_lo=0x8F, div_by_zero=0.
- WIDTH=8, mul 255×255 → result_hi=0xFE, result_lo=0x01.
- WIDTH=8, div 200/7 → result_lo=0x1C, result_hi=0x04; then div 77/0 → result_lo=0xFF, result_hi=0x4D, div_by_zero=1.
- start pulsed at cycles k+3 and k+5 during a busy mul → ignored, exactly one done at k+9. start held at FINISH → second op done at k+18.
- rst_n low at k+4 of a divide → busy/done/results read 0 immediately; no done pulse; a fresh op afterwards is correct.
- MULDIV_SIGNED_EN, is_signed=1, WIDTH=8:
  - (-6)×7 → {hi,lo}=0xFFD6
  - (-7)/2 → lo=0xFD, hi=0xFF
  - (-128)/(-1) → lo=0x80, hi=0x00
